mix_columns_ark: RTL and testbench



---
 rtl/mix_columns_ark_pkg.sv | 25 ++
 rtl/params_if.sv | 10 +
 rtl/mix_columns_ark_column.sv | 40 ++++
 rtl/mix_columns_ark.sv | 109 ++++++++++
 tb/tb_mix_columns_ark.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_ark_pkg.sv
// Shared types for the CLM masked AES MixColumns/AddRoundKey stage: redundant
// polynomial widths, state containers, xtime helper and the stage FSM states.
package mix_columns_ark_pkg;

  localparam int R_DEG = 8;
  localparam int RED_W = 8 + R_DEG;

  typedef logic [RED_W-1:0] red_poly_t;
  typedef red_poly_t [0:3] state_word_t;
  typedef state_word_t [0:3] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Multiply by x modulo the redundant modulus M(x); never reduced mod P(x).
  function automatic red_poly_t red_xtime(red_poly_t a, red_poly_t mod_poly);
    red_poly_t sh;
    sh = {a[RED_W-2:0], 1'b0};
    return a[RED_W-1] ? (sh ^ mod_poly) : sh;
  endfunction

endpackage

// File: rtl/params_if.sv
// Shared datapath parameters; mod_poly holds the low RED_W bits of M(x) = P(x)*R(x)
// with the leading term implicit.
interface params_if;
  import mix_columns_ark_pkg::*;

  red_poly_t mod_poly;

  modport in_use (input mod_poly);
  modport drive  (output mod_poly);
endinterface

// File: rtl/mix_columns_ark_column.sv
// Combinational single-column MixColumns with round-key XOR and last-round bypass.
// Optional refresh XOR is built only when CLM_MC_REFRESH_EN is defined.
module mc_column
  import mix_columns_ark_pkg::*;
(
  input  state_word_t a,
  input  state_word_t key,
  input  state_word_t refresh,
  input  logic        last_round,
  input  red_poly_t   mod_poly,
  output state_word_t o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      red_poly_t x_self;
      red_poly_t x_next;
      red_poly_t mixed;
      red_poly_t plain;

      // Row r of the circulant (2,3,1,1): 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
      assign x_self = red_xtime(a[gi], mod_poly);
      assign x_next = red_xtime(a[(gi+1)%4], mod_poly);
      assign mixed  = x_self ^ x_next ^ a[(gi+1)%4] ^ a[(gi+2)%4] ^ a[(gi+3)%4];
      assign plain  = last_round ? a[gi] : mixed;
`ifdef CLM_MC_REFRESH_EN
      assign o[gi] = plain ^ key[gi] ^ refresh[gi];
`else
      assign o[gi] = plain ^ key[gi];
`endif
    end
  endgenerate

`ifndef CLM_MC_REFRESH_EN
  logic unused_refresh;
  assign unused_refresh = ^refresh;
`endif

endmodule

// File: rtl/mix_columns_ark.sv
// Column-serial MixColumns + AddRoundKey stage: captures a ShiftRows'ed state,
// emits one column per cycle, then pulses drdy_o. Optional macro: CLM_MC_REFRESH_EN.
module mix_columns_ark
  import mix_columns_ark_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  params_if.in_use    params,
  input  logic        active,
  input  logic        drdy_i,
  input  logic        last_round,
  input  state_t      in,
  input  state_t      round_key,
  input  state_word_t refresh,
  output state_t      out,
  output logic        drdy_o,
  output logic        busy
);

  mc_state_e   state_reg, state_next;
  logic [1:0]  counter_reg, counter_next;
  state_t      s_reg, key_reg, out_reg, shifted;
  logic        last_reg;
  logic        capture, write_col;
  state_word_t col_out;

  // ShiftRows is pure wiring on the captured input
  genvar gi, gr;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign shifted[gi][gr] = in[(gi+gr)%4][gr];
      end
    end
  endgenerate

  mc_column u_column (
    .a          (s_reg[counter_reg]),
    .key        (key_reg[counter_reg]),
    .refresh    (refresh),
    .last_round (last_reg),
    .mod_poly   (params.mod_poly),
    .o          (col_out)
  );

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    capture      = 1'b0;
    write_col    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (drdy_i && active) begin
          capture      = 1'b1;
          state_next   = RUN;
          counter_next = 2'd0;
        end
      end
      RUN: begin
        if (!active) begin
          state_next   = IDLE;
          counter_next = 2'd0;
        end else begin
          write_col    = 1'b1;
          counter_next = counter_reg + 2'd1;
          if (counter_reg == 2'd3) state_next = DONE;
        end
      end
      DONE: begin
        counter_next = 2'd0;
        if (drdy_i && active) begin
          capture    = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      counter_reg <= 2'd0;
      s_reg       <= '0;
      key_reg     <= '0;
      last_reg    <= 1'b0;
      out_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      if (capture) begin
        s_reg    <= shifted;
        key_reg  <= round_key;
        last_reg <= last_round;
      end
      if (write_col) out_reg[counter_reg] <= col_out;
    end
  end

  assign out    = out_reg;
  assign drdy_o = (state_reg == DONE);
  assign busy   = (state_reg == RUN);

endmodule

// File: tb/tb_mix_columns_ark.sv
// Scoreboard bench for mix_columns_ark: stimulus pushes model results, a negedge
// monitor pops and compares on every drdy_o pulse.
module tb_mix_columns_ark;
  import mix_columns_ark_pkg::*;

`ifdef CLM_MC_REFRESH_EN
  localparam bit REFRESH_ON = 1'b1;
`else
  localparam bit REFRESH_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        active, drdy_i, last_round;
  state_t      in_st, round_key, out;
  state_word_t refresh;
  logic        drdy_o, busy;
  red_poly_t   mod_poly;
  logic [RED_W:0] m_full;

  params_if pif ();
  assign pif.mod_poly = mod_poly;

  mix_columns_ark dut (
    .clk        (clk),
    .rst        (rst),
    .params     (pif),
    .active     (active),
    .drdy_i     (drdy_i),
    .last_round (last_round),
    .in         (in_st),
    .round_key  (round_key),
    .refresh    (refresh),
    .out        (out),
    .drdy_o     (drdy_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int txn = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    state_t exp;
    state_t unref;
    logic   use_const;
    state_t const_st;
    logic   chk_diff;
    int     acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic ok, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Carry-less product of two polynomials over GF(2)
  function automatic logic [RED_W:0] clmul(input logic [RED_W:0] a, input logic [RED_W:0] b);
    logic [RED_W:0] p;
    p = '0;
    for (int i = 0; i <= RED_W; i++) if (b[i]) p ^= a << i;
    return p;
  endfunction

  function automatic red_poly_t codeword(input int k);
    logic [RED_W:0] p, kk;
    p  = (RED_W+1)'(9'h11B);
    kk = (RED_W+1)'(k);
    return red_poly_t'(clmul(p, kk));
  endfunction

  // a * k mod M(x) by long division, k in {1,2,3}
  function automatic red_poly_t gmul(input red_poly_t a, input int k);
    logic [RED_W+1:0] p, m;
    logic [1:0] kb;
    p  = '0;
    kb = 2'(k);
    m  = {1'b0, m_full};
    for (int i = 0; i < 2; i++) if (kb[i]) p ^= {2'b00, a} << i;
    for (int b = RED_W + 1; b >= RED_W; b--) if (p[b]) p ^= m << (b - RED_W);
    return p[RED_W-1:0];
  endfunction

  function automatic logic [7:0] red_p(input red_poly_t x);
    red_poly_t v, p;
    v = x;
    p = red_poly_t'(9'h11B);
    for (int b = RED_W - 1; b >= 8; b--) if (v[b]) v ^= p << (b - 8);
    return v[7:0];
  endfunction

  function automatic state_t model(input state_t st, input state_t key, input logic last,
                                   input state_t rf, input logic use_rf);
    state_t    res;
    red_poly_t col[4];
    red_poly_t acc;
    int        coef[4];
    coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[r] = st[(c + r) % 4][r];
      for (int r = 0; r < 4; r++) begin
        if (last) acc = col[r];
        else begin
          acc = '0;
          for (int j = 0; j < 4; j++) acc ^= gmul(col[j], coef[(j - r + 4) % 4]);
        end
        res[c][r] = acc ^ key[c][r] ^ ((use_rf && REFRESH_ON) ? rf[c][r] : '0);
      end
    end
    return res;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[c][r] = red_poly_t'($urandom);
    return s;
  endfunction

  task automatic send(input state_t st, input state_t key, input logic last, input state_t rf,
                      input logic use_const, input state_t cst, input logic chk_diff,
                      input logic chk_hold, input state_t prev);
    exp_t e;
    in_st = st; round_key = key; last_round = last; drdy_i = 1'b1;
    @(posedge clk); #1;
    drdy_i     = 1'b0;
    e.exp      = model(st, key, last, rf, 1'b1);
    e.unref    = model(st, key, last, rf, 1'b0);
    e.use_const = use_const;
    e.const_st = cst;
    e.chk_diff = chk_diff;
    e.acc      = cyc;
    sb.push_back(e);
    in_st = rand_state();
    round_key = rand_state();
    for (int c = 0; c < 4; c++) begin
      refresh = rf[c];
      // drdy_i in RUN must be ignored
      drdy_i  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (chk_hold && c < 3)
        chk("hold_col3", out[3] == prev[3], 256'(out[3]), 256'(prev[3]));
    end
    drdy_i = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t   e;
    state_t red;
    if (drdy_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_drdy", 1'b0, 256'(1), 256'(0));
      end else begin
        e = sb.pop_front();
        txn++;
        chk("out", out == e.exp, out, e.exp);
        chk("latency", (cyc - e.acc + 1) == 5, 256'(cyc - e.acc + 1), 256'(5));
        if (e.use_const) begin
          for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) red[c][r] = red_poly_t'(red_p(out[c][r]));
          chk("reduced_mod_p", red == e.const_st, red, e.const_st);
        end
        if (e.chk_diff) chk("refresh_diff", out != e.unref, out, e.unref);
        $display("txn %0d at cycle %0d checked", txn, cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no_finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    state_t zero, st1, cst, key, rf, a, b, pa;
    logic [RED_W:0] rpoly;
    int     ks[4];
    int     gap;

    zero = '0;
    rst = 1'b1; active = 1'b0; drdy_i = 1'b0; last_round = 1'b0;
    in_st = '0; round_key = '0; refresh = '0;
    rpoly  = (RED_W+1)'({1'b1, 7'($urandom), 1'b1});
    m_full = clmul((RED_W+1)'(9'h11B), rpoly);
    mod_poly = m_full[RED_W-1:0];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", out == '0, out, 256'(0));
    chk("reset_drdy", drdy_o == 1'b0, 256'(drdy_o), 256'(0));
    chk("reset_busy", busy == 1'b0, 256'(busy), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0; active = 1'b1;
    @(posedge clk); #1;

    // Test 1: AES reference column (db,13,53,45) -> (8e,4d,a1,bc) mod P
    for (int c = 0; c < 4; c++) begin
      st1[c] = '{16'h00db, 16'h0013, 16'h0053, 16'h0045};
      cst[c] = '{16'h008e, 16'h004d, 16'h00a1, 16'h00bc};
    end
    send(st1, zero, 1'b0, zero, 1'b1, cst, 1'b0, 1'b0, zero);
    @(posedge clk); #1;

    // Test 2: last round with key column (01,02,03,04)
    for (int c = 0; c < 4; c++) begin
      key[c] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      cst[c] = '{16'h00da, 16'h0011, 16'h0050, 16'h0041};
    end
    send(st1, key, 1'b1, zero, 1'b1, cst, 1'b0, 1'b0, zero);
    @(posedge clk); #1;

    // Test 3: ShiftRows visible through last-round bypass
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        a[c][r]   = red_poly_t'(16 * c + r);
        cst[c][r] = red_poly_t'(16 * ((c + r) % 4) + r);
      end
    send(a, zero, 1'b1, zero, 1'b1, cst, 1'b0, 1'b0, zero);
    @(posedge clk); #1;

    // Test 4: back-to-back acceptance in DONE, first result held column by column
    a = rand_state(); key = rand_state(); rf = rand_state();
    send(a, key, 1'b0, rf, 1'b0, zero, 1'b0, 1'b0, zero);
    pa = model(a, key, 1'b0, rf, 1'b1);
    b = rand_state(); key = rand_state(); rf = rand_state();
    send(b, key, 1'b1, rf, 1'b0, zero, 1'b0, 1'b1, pa);
    @(posedge clk); #1;

    // Test 5: reset two cycles into RUN discards the partial result
    in_st = rand_state(); round_key = rand_state(); last_round = 1'b0; drdy_i = 1'b1;
    @(posedge clk); #1;
    drdy_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_before_rst", busy == 1'b1, 256'(busy), 256'(1));
    rst = 1'b1;
    #2;
    chk("rst_out", out == '0, out, 256'(0));
    chk("rst_drdy", drdy_o == 1'b0, 256'(drdy_o), 256'(0));
    chk("rst_busy", busy == 1'b0, 256'(busy), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(st1, zero, 1'b0, zero, 1'b1, cst_t1(), 1'b0, 1'b0, zero);
    @(posedge clk); #1;

    // Active dropped mid-RUN: back to IDLE, no result
    in_st = rand_state(); drdy_i = 1'b1;
    @(posedge clk); #1;
    drdy_i = 1'b0;
    @(posedge clk); #1;
    active = 1'b0;
    @(posedge clk); #1;
    chk("active_drop_busy", busy == 1'b0, 256'(busy), 256'(0));
    repeat (6) begin @(posedge clk); #1; end
    active = 1'b1;

    // Test 6: refresh codewords P*k, k in {1,2,3,5}; same value mod P
    ks = '{1, 2, 3, 5};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) rf[c][r] = codeword(ks[(c + r) % 4]);
    send(st1, zero, 1'b0, rf, 1'b1, cst_t1(), REFRESH_ON, 1'b0, zero);
    @(posedge clk); #1;

    // Random traffic with random gaps (gap 0 exercises back-to-back)
    for (int t = 0; t < 20; t++) begin
      a = rand_state(); key = rand_state();
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) rf[c][r] = codeword($urandom_range(0, 127));
      send(a, key, 1'($urandom_range(0, 1)), rf, 1'b0, zero, 1'b0, 1'b0, zero);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size() == 0, 256'(sb.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic state_t cst_t1();
    state_t s;
    for (int c = 0; c < 4; c++) s[c] = '{16'h008e, 16'h004d, 16'h00a1, 16'h00bc};
    return s;
  endfunction

endmodule
